// File: rtl/riscv_pkg.sv
// Shared RV32I control definitions: opcodes, ALU op encodings, sequencer
// states and the decoded-opcode payload.
package riscv_pkg;

  localparam int unsigned OPC_W = 7;

  localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] ALUOP_ARITH  = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_ADDR   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef struct packed {
    logic       legal;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jump;
    logic       writes_rd;
    logic [1:0] alu_op;
    logic       alu_src;
  } op_dec_t;

endpackage

// File: rtl/riscv_op_decode.sv
// Combinational opcode classifier shared by the single-cycle and
// multi-cycle control paths.
//  opcode  in   7  instr[6:0]
//  dec     out     legality, class flags and ALU control for the opcode
module riscv_op_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output op_dec_t    dec
);

  always_comb begin
    dec = '0;
    case (opcode)
      OP_R:      begin dec.legal = 1'b1; dec.writes_rd = 1'b1; dec.alu_op = ALUOP_ARITH; end
      OP_IMM:    begin dec.legal = 1'b1; dec.writes_rd = 1'b1; dec.alu_op = ALUOP_ARITH; dec.alu_src = 1'b1; end
      OP_LOAD:   begin dec.legal = 1'b1; dec.is_load = 1'b1; dec.writes_rd = 1'b1;
                       dec.alu_op = ALUOP_ADDR; dec.alu_src = 1'b1; end
      OP_STORE:  begin dec.legal = 1'b1; dec.is_store = 1'b1; dec.alu_op = ALUOP_ADDR; dec.alu_src = 1'b1; end
      OP_BRANCH: begin dec.legal = 1'b1; dec.is_branch = 1'b1; dec.alu_op = ALUOP_BRANCH; end
      OP_LUI,
      OP_AUIPC:  begin dec.legal = 1'b1; dec.writes_rd = 1'b1; dec.alu_op = ALUOP_ARITH; dec.alu_src = 1'b1; end
      OP_JAL:    begin dec.legal = 1'b1; dec.writes_rd = 1'b1; dec.is_jump = 1'b1; end
      OP_JALR:   begin dec.legal = 1'b1; dec.writes_rd = 1'b1; dec.is_jump = 1'b1; dec.alu_src = 1'b1; end
      default:   dec = '0;
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_sequencer.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with variable
// latency memory handshakes, memory timeout trap and retired-instruction count.
//  clk, rst (async, active-high)       run: stop at next instruction boundary when 0
//  opcode: IR[6:0], sampled in DECODE  imem_ready / dmem_ready: one-cycle responses
//  imem_req, dmem_req, dmem_we         memory requests, held until ready
//  ir_write, pc_write, reg_write       datapath write pulses
//  alu_src, alu_op, branch, jump       ALU / PC control in EXEC (MEM holds ALU ctl)
//  busy, trap (sticky), instret        status
module riscv_multicycle_sequencer
  import riscv_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [6:0]  opcode,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic        branch,
  output logic        jump,
  output logic        busy,
  output logic        trap,
  output logic [31:0] instret
);

  state_t           state_q, state_d;
  logic [6:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      instret_q;
  logic [6:0]       dec_op;
  op_dec_t          dec;
  logic             timeout;

  // DECODE classifies the live IR opcode; later states use the latched copy.
  assign dec_op = (state_q == S_DECODE) ? opcode : op_q;

  riscv_op_decode u_dec (
    .opcode (dec_op),
    .dec    (dec)
  );

  // Last permitted wait cycle; a ready in this cycle still wins.
  assign timeout = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  begin
        if (imem_ready)   state_d = S_DECODE;
        else if (timeout) state_d = S_TRAP;
      end
      S_DECODE: state_d = dec.legal ? S_EXEC : S_TRAP;
      S_EXEC:   begin
        if (dec.is_load || dec.is_store) state_d = S_MEM;
        else if (dec.is_branch)          state_d = run ? S_FETCH : S_IDLE;
        else                             state_d = S_WB;
      end
      S_MEM:    begin
        if (dmem_ready)   state_d = dec.is_store ? (run ? S_FETCH : S_IDLE) : S_WB;
        else if (timeout) state_d = S_TRAP;
      end
      S_WB:     state_d = run ? S_FETCH : S_IDLE;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode from state and latched opcode; ready qualifies the write pulses
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    alu_src   = 1'b0;
    alu_op    = ALUOP_ARITH;
    branch    = 1'b0;
    jump      = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
      end
      S_EXEC: begin
        alu_op   = dec.alu_op;
        alu_src  = dec.alu_src;
        branch   = dec.is_branch;
        jump     = dec.is_jump;
        pc_write = dec.is_branch;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec.is_store;
        alu_op   = dec.alu_op;
        alu_src  = dec.alu_src;
        pc_write = dec.is_store && dmem_ready;
      end
      S_WB: begin
        reg_write = dec.writes_rd;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
    busy = (state_q != S_IDLE) && (state_q != S_TRAP);
    trap = (state_q == S_TRAP);
  end

  // Opcode latch, memory wait counter and retirement counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= '0;
      cnt_q     <= '0;
      instret_q <= '0;
    end else begin
      if (state_q == S_DECODE) op_q <= opcode;
      if (state_d != state_q)
        cnt_q <= '0;
      else if ((state_q == S_FETCH) || (state_q == S_MEM))
        cnt_q <= cnt_q + CNT_W'(1);
      if (pc_write) instret_q <= instret_q + 32'd1;
    end
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_riscv_multicycle_sequencer.sv
// Directed bench for riscv_multicycle_sequencer with MEM_TIMEOUT=4.
module tb_riscv_multicycle_sequencer;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BAD    = 7'b1111111;

  // {imem_req,dmem_req,dmem_we,ir_write,pc_write,reg_write,alu_src,alu_op[1:0],branch,jump,busy,trap}
  localparam logic [12:0] E_IDLE   = 13'h0000;
  localparam logic [12:0] E_FW     = 13'h1002;
  localparam logic [12:0] E_FR     = 13'h1202;
  localparam logic [12:0] E_DEC    = 13'h0002;
  localparam logic [12:0] E_EX_R   = 13'h0002;
  localparam logic [12:0] E_EX_I   = 13'h0042;
  localparam logic [12:0] E_EX_LS  = 13'h0062;
  localparam logic [12:0] E_EX_BR  = 13'h011A;
  localparam logic [12:0] E_EX_J   = 13'h0006;
  localparam logic [12:0] E_MEM_L  = 13'h0862;
  localparam logic [12:0] E_MEM_SW = 13'h0C62;
  localparam logic [12:0] E_MEM_SR = 13'h0D62;
  localparam logic [12:0] E_WB     = 13'h0182;
  localparam logic [12:0] E_TRAP   = 13'h0001;

  typedef struct packed {
    logic [6:0]  op;
    logic        run;
    logic        ir;
    logic        dr;
    logic [12:0] want;
  } row_t;

  logic        clk = 1'b0;
  logic        rst, run, imem_ready, dmem_ready;
  logic [6:0]  opcode;
  logic        imem_req, dmem_req, dmem_we, ir_write, pc_write, reg_write;
  logic        alu_src, branch, jump, busy, trap;
  logic [1:0]  alu_op;
  logic [31:0] instret;
  logic [12:0] outs;
  logic [31:0] exp_instret;
  int          total = 0;
  int          bad = 0;

  riscv_multicycle_sequencer #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src(alu_src), .alu_op(alu_op), .branch(branch), .jump(jump),
    .busy(busy), .trap(trap), .instret(instret)
  );

  always #5 clk = ~clk;

  assign outs = {imem_req, dmem_req, dmem_we, ir_write, pc_write, reg_write,
                 alu_src, alu_op, branch, jump, busy, trap};

  // Apply one row of stimulus at the falling edge and let outputs settle.
  task automatic drive(input row_t r);
    @(negedge clk);
    opcode = r.op; run = r.run; imem_ready = r.ir; dmem_ready = r.dr;
    #1;
  endtask

  // Assert reset mid-cycle, away from any clock edge.
  task automatic assert_reset();
    @(negedge clk);
    #2;
    rst = 1'b1; run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    #1;
    exp_instret = 32'd0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; opcode = OPC_R;
    exp_instret = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (outs !== E_IDLE) begin bad++; $display("FAIL reset_outs got=%h want=%h", outs, E_IDLE); end
    total++;
    if (instret !== 32'd0) begin bad++; $display("FAIL reset_instret got=%0d want=0", instret); end
    release_reset();
    @(negedge clk); #1;
    total++;
    if (outs !== E_IDLE) begin bad++; $display("FAIL reset_idle got=%h want=%h", outs, E_IDLE); end
  endtask

  task automatic test_rtype();
    row_t t [9] = '{
      '{OPC_R, 1'b1, 1'b0, 1'b0, E_IDLE},
      '{OPC_R, 1'b1, 1'b0, 1'b0, E_FW},
      '{OPC_R, 1'b1, 1'b0, 1'b0, E_FW},
      '{OPC_R, 1'b1, 1'b0, 1'b0, E_FW},
      '{OPC_R, 1'b1, 1'b1, 1'b0, E_FR},
      '{OPC_R, 1'b1, 1'b0, 1'b0, E_DEC},
      '{OPC_R, 1'b1, 1'b0, 1'b0, E_EX_R},
      '{OPC_R, 1'b0, 1'b0, 1'b0, E_WB},
      '{OPC_R, 1'b0, 1'b0, 1'b0, E_IDLE}};
    foreach (t[i]) begin
      drive(t[i]);
      total++;
      if (outs !== t[i].want) begin bad++; $display("FAIL rtype[%0d] got=%h want=%h", i, outs, t[i].want); end
    end
    exp_instret = exp_instret + 32'd1;
    total++;
    if (instret !== exp_instret) begin bad++; $display("FAIL rtype_instret got=%0d want=%0d", instret, exp_instret); end
  endtask

  // run drops while the load is in MEM; the load still writes back.
  task automatic test_load();
    row_t t [9] = '{
      '{OPC_LOAD, 1'b1, 1'b0, 1'b0, E_IDLE},
      '{OPC_LOAD, 1'b1, 1'b1, 1'b0, E_FR},
      '{OPC_LOAD, 1'b1, 1'b0, 1'b0, E_DEC},
      '{OPC_LOAD, 1'b1, 1'b0, 1'b0, E_EX_LS},
      '{OPC_LOAD, 1'b0, 1'b0, 1'b0, E_MEM_L},
      '{OPC_LOAD, 1'b0, 1'b0, 1'b0, E_MEM_L},
      '{OPC_LOAD, 1'b0, 1'b0, 1'b1, E_MEM_L},
      '{OPC_LOAD, 1'b0, 1'b0, 1'b0, E_WB},
      '{OPC_LOAD, 1'b0, 1'b0, 1'b0, E_IDLE}};
    foreach (t[i]) begin
      drive(t[i]);
      total++;
      if (outs !== t[i].want) begin bad++; $display("FAIL load[%0d] got=%h want=%h", i, outs, t[i].want); end
    end
    exp_instret = exp_instret + 32'd1;
    total++;
    if (instret !== exp_instret) begin bad++; $display("FAIL load_instret got=%0d want=%0d", instret, exp_instret); end
  endtask

  task automatic test_store();
    row_t t [7] = '{
      '{OPC_STORE, 1'b1, 1'b0, 1'b0, E_IDLE},
      '{OPC_STORE, 1'b1, 1'b1, 1'b0, E_FR},
      '{OPC_STORE, 1'b1, 1'b0, 1'b0, E_DEC},
      '{OPC_STORE, 1'b1, 1'b0, 1'b0, E_EX_LS},
      '{OPC_STORE, 1'b1, 1'b0, 1'b0, E_MEM_SW},
      '{OPC_STORE, 1'b0, 1'b0, 1'b1, E_MEM_SR},
      '{OPC_STORE, 1'b0, 1'b0, 1'b0, E_IDLE}};
    foreach (t[i]) begin
      drive(t[i]);
      total++;
      if (outs !== t[i].want) begin bad++; $display("FAIL store[%0d] got=%h want=%h", i, outs, t[i].want); end
    end
    exp_instret = exp_instret + 32'd1;
    total++;
    if (instret !== exp_instret) begin bad++; $display("FAIL store_instret got=%0d want=%0d", instret, exp_instret); end
  endtask

  task automatic test_branch();
    row_t t [5] = '{
      '{OPC_BRANCH, 1'b1, 1'b0, 1'b0, E_IDLE},
      '{OPC_BRANCH, 1'b1, 1'b1, 1'b0, E_FR},
      '{OPC_BRANCH, 1'b1, 1'b0, 1'b0, E_DEC},
      '{OPC_BRANCH, 1'b0, 1'b0, 1'b0, E_EX_BR},
      '{OPC_BRANCH, 1'b0, 1'b0, 1'b0, E_IDLE}};
    foreach (t[i]) begin
      drive(t[i]);
      total++;
      if (outs !== t[i].want) begin bad++; $display("FAIL branch[%0d] got=%h want=%h", i, outs, t[i].want); end
    end
    exp_instret = exp_instret + 32'd1;
    total++;
    if (instret !== exp_instret) begin bad++; $display("FAIL branch_instret got=%0d want=%0d", instret, exp_instret); end
  endtask

  // R, I and JAL retire without a stop, then stray readies hit an idle FSM.
  task automatic test_back_to_back();
    row_t t [16] = '{
      '{OPC_R,   1'b1, 1'b0, 1'b0, E_IDLE},
      '{OPC_R,   1'b1, 1'b1, 1'b0, E_FR},
      '{OPC_R,   1'b1, 1'b0, 1'b0, E_DEC},
      '{OPC_R,   1'b1, 1'b0, 1'b0, E_EX_R},
      '{OPC_R,   1'b1, 1'b0, 1'b0, E_WB},
      '{OPC_IMM, 1'b1, 1'b1, 1'b0, E_FR},
      '{OPC_IMM, 1'b1, 1'b0, 1'b1, E_DEC},
      '{OPC_IMM, 1'b1, 1'b0, 1'b0, E_EX_I},
      '{OPC_IMM, 1'b1, 1'b0, 1'b0, E_WB},
      '{OPC_JAL, 1'b1, 1'b1, 1'b0, E_FR},
      '{OPC_JAL, 1'b1, 1'b0, 1'b0, E_DEC},
      '{OPC_JAL, 1'b1, 1'b0, 1'b0, E_EX_J},
      '{OPC_JAL, 1'b0, 1'b0, 1'b0, E_WB},
      '{OPC_JAL, 1'b0, 1'b0, 1'b0, E_IDLE},
      '{OPC_JAL, 1'b0, 1'b1, 1'b1, E_IDLE},
      '{OPC_JAL, 1'b0, 1'b0, 1'b0, E_IDLE}};
    foreach (t[i]) begin
      drive(t[i]);
      total++;
      if (outs !== t[i].want) begin bad++; $display("FAIL b2b[%0d] got=%h want=%h", i, outs, t[i].want); end
    end
    exp_instret = exp_instret + 32'd3;
    total++;
    if (instret !== exp_instret) begin bad++; $display("FAIL b2b_instret got=%0d want=%0d", instret, exp_instret); end
  endtask

  // Ready on the 4th FETCH cycle wins; no ready at all traps after 4 cycles.
  task automatic test_fetch_timeout();
    row_t t [16] = '{
      '{OPC_IMM, 1'b1, 1'b0, 1'b0, E_IDLE},
      '{OPC_IMM, 1'b1, 1'b0, 1'b0, E_FW},
      '{OPC_IMM, 1'b1, 1'b0, 1'b0, E_FW},
      '{OPC_IMM, 1'b1, 1'b0, 1'b0, E_FW},
      '{OPC_IMM, 1'b1, 1'b1, 1'b0, E_FR},
      '{OPC_IMM, 1'b1, 1'b0, 1'b0, E_DEC},
      '{OPC_IMM, 1'b1, 1'b0, 1'b0, E_EX_I},
      '{OPC_IMM, 1'b0, 1'b0, 1'b0, E_WB},
      '{OPC_IMM, 1'b1, 1'b0, 1'b0, E_IDLE},
      '{OPC_IMM, 1'b1, 1'b0, 1'b0, E_FW},
      '{OPC_IMM, 1'b1, 1'b0, 1'b0, E_FW},
      '{OPC_IMM, 1'b1, 1'b0, 1'b0, E_FW},
      '{OPC_IMM, 1'b1, 1'b0, 1'b0, E_FW},
      '{OPC_IMM, 1'b1, 1'b0, 1'b0, E_TRAP},
      '{OPC_IMM, 1'b1, 1'b1, 1'b0, E_TRAP},
      '{OPC_IMM, 1'b1, 1'b0, 1'b0, E_TRAP}};
    foreach (t[i]) begin
      drive(t[i]);
      total++;
      if (outs !== t[i].want) begin bad++; $display("FAIL ftimeout[%0d] got=%h want=%h", i, outs, t[i].want); end
    end
    exp_instret = exp_instret + 32'd1;
    total++;
    if (instret !== exp_instret) begin bad++; $display("FAIL ftimeout_instret got=%0d want=%0d", instret, exp_instret); end
    assert_reset();
    release_reset();
  endtask

  task automatic test_illegal();
    row_t t [7] = '{
      '{OPC_BAD, 1'b1, 1'b0, 1'b0, E_IDLE},
      '{OPC_BAD, 1'b1, 1'b1, 1'b0, E_FR},
      '{OPC_BAD, 1'b1, 1'b0, 1'b0, E_DEC},
      '{OPC_BAD, 1'b0, 1'b0, 1'b0, E_TRAP},
      '{OPC_BAD, 1'b1, 1'b1, 1'b1, E_TRAP},
      '{OPC_R,   1'b0, 1'b0, 1'b0, E_TRAP},
      '{OPC_R,   1'b1, 1'b0, 1'b0, E_TRAP}};
    foreach (t[i]) begin
      drive(t[i]);
      total++;
      if (outs !== t[i].want) begin bad++; $display("FAIL illegal[%0d] got=%h want=%h", i, outs, t[i].want); end
    end
    assert_reset();
    total++;
    if (outs !== E_IDLE) begin bad++; $display("FAIL illegal_rst got=%h want=%h", outs, E_IDLE); end
    release_reset();
    @(negedge clk); #1;
    total++;
    if (outs !== E_IDLE) begin bad++; $display("FAIL illegal_after_rst got=%h want=%h", outs, E_IDLE); end
  endtask

  task automatic test_dmem_timeout();
    row_t t [10] = '{
      '{OPC_LOAD, 1'b1, 1'b0, 1'b0, E_IDLE},
      '{OPC_LOAD, 1'b1, 1'b1, 1'b0, E_FR},
      '{OPC_LOAD, 1'b1, 1'b0, 1'b0, E_DEC},
      '{OPC_LOAD, 1'b1, 1'b0, 1'b0, E_EX_LS},
      '{OPC_LOAD, 1'b1, 1'b0, 1'b0, E_MEM_L},
      '{OPC_LOAD, 1'b1, 1'b0, 1'b0, E_MEM_L},
      '{OPC_LOAD, 1'b1, 1'b0, 1'b0, E_MEM_L},
      '{OPC_LOAD, 1'b1, 1'b0, 1'b0, E_MEM_L},
      '{OPC_LOAD, 1'b1, 1'b0, 1'b1, E_TRAP},
      '{OPC_LOAD, 1'b0, 1'b0, 1'b0, E_TRAP}};
    foreach (t[i]) begin
      drive(t[i]);
      total++;
      if (outs !== t[i].want) begin bad++; $display("FAIL dtimeout[%0d] got=%h want=%h", i, outs, t[i].want); end
    end
    assert_reset();
    release_reset();
  endtask

  // Reset in the middle of a store access drops the request immediately.
  task automatic test_rst_mid_mem();
    row_t t [5] = '{
      '{OPC_STORE, 1'b1, 1'b0, 1'b0, E_IDLE},
      '{OPC_STORE, 1'b1, 1'b1, 1'b0, E_FR},
      '{OPC_STORE, 1'b1, 1'b0, 1'b0, E_DEC},
      '{OPC_STORE, 1'b1, 1'b0, 1'b0, E_EX_LS},
      '{OPC_STORE, 1'b1, 1'b0, 1'b0, E_MEM_SW}};
    foreach (t[i]) begin
      drive(t[i]);
      total++;
      if (outs !== t[i].want) begin bad++; $display("FAIL rstmem[%0d] got=%h want=%h", i, outs, t[i].want); end
    end
    #2;
    rst = 1'b1; run = 1'b0;
    #1;
    exp_instret = 32'd0;
    total++;
    if (outs !== E_IDLE) begin bad++; $display("FAIL rstmem_async got=%h want=%h", outs, E_IDLE); end
    total++;
    if (instret !== exp_instret) begin bad++; $display("FAIL rstmem_instret got=%0d want=%0d", instret, exp_instret); end
    release_reset();
    @(negedge clk); #1;
    total++;
    if (outs !== E_IDLE) begin bad++; $display("FAIL rstmem_idle got=%h want=%h", outs, E_IDLE); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load();
    test_store();
    test_branch();
    test_back_to_back();
    test_fetch_timeout();
    test_illegal();
    test_dmem_timeout();
    test_rst_mid_mem();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
